// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register carrying an instruction word and its PC.
// in_ready is derived from registered state only, so back-pressure never forms a combinational path.
module pipe_skid_reg #(
  parameter int                  WIDTH    = 16,
  parameter int                  PC_WIDTH = 16,
  parameter logic [WIDTH-1:0]    NOP_WORD = '0
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  input  logic [PC_WIDTH-1:0] in_pc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [1:0]          occupancy
);

  // Encoding equals the number of held words, so occupancy is the state itself.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      main_data_q, main_data_d;
  logic [PC_WIDTH-1:0]   main_pc_q,   main_pc_d;
  logic [WIDTH-1:0]      skid_data_q, skid_data_d;
  logic [PC_WIDTH-1:0]   skid_pc_q,   skid_pc_d;

  logic accept;
  logic consume;

  assign in_ready  = (state_q != S_FULL);
  assign out_valid = (state_q != S_EMPTY);
  assign out_data  = out_valid ? main_data_q : NOP_WORD;
  assign out_pc    = out_valid ? main_pc_q   : '0;
  assign occupancy = state_q;

  assign accept  = in_valid  & in_ready;
  assign consume = out_valid & out_ready;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    main_data_d = main_data_q;
    main_pc_d   = main_pc_q;
    skid_data_d = skid_data_q;
    skid_pc_d   = skid_pc_q;

    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d     = S_ONE;
            main_data_d = in_data;
            main_pc_d   = in_pc;
          end
        end
        S_ONE: begin
          if (accept && consume) begin
            main_data_d = in_data;
            main_pc_d   = in_pc;
          end else if (accept) begin
            state_d     = S_FULL;
            skid_data_d = in_data;
            skid_pc_d   = in_pc;
          end else if (consume) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          // Skid word moves up behind the departing head, keeping FIFO order.
          if (consume) begin
            state_d     = S_ONE;
            main_data_d = skid_data_q;
            main_pc_d   = skid_pc_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // NOTE: the data entries are reset too; only two words, and it keeps post-reset contents deterministic.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= S_EMPTY;
      main_data_q <= '0;
      main_pc_q   <= '0;
      skid_data_q <= '0;
      skid_pc_q   <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge value of the others.
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_pc_q   <= main_pc_d;
      skid_data_q <= skid_data_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: the driver queues each accepted word, a negedge monitor
// pops and compares whenever the DUT hands a word to the consumer.
module tb_pipe_skid_reg;

  logic        CLK;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [15:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [15:0] out_pc;
  logic [1:0]  occupancy;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];

  pipe_skid_reg #(
    .WIDTH    (16),
    .PC_WIDTH (16),
    .NOP_WORD (16'h0000)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_pc    (out_pc),
    .occupancy (occupancy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a word is consumed at the next rising edge when valid & ready are high now.
  always @(negedge CLK) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %h/%h expected none at %0t", out_data, out_pc, $time);
      end else begin
        check("out_word", {out_data, out_pc}, exp_q.pop_front());
      end
    end
  end

  // One clock of stimulus; queues the word if it will be accepted and not squashed.
  task automatic drive(input logic v, input logic [15:0] d, input logic [15:0] pc,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(negedge CLK);
    if (v && in_ready && !fl) exp_q.push_back({d, pc});
    @(posedge CLK);
    #1;
    if (fl) exp_q.delete();
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 16'hDEAD, 16'hBEEF, ordy, 1'b0);
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1234;
    in_pc     = 16'h00FF;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset with a word presented on the input
    repeat (2) @(posedge CLK);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'h0000);
    check("rst_out_pc",    32'(out_pc),    32'h0000);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge CLK);
    #1;
    check("rst_release_occ", 32'(occupancy), 32'd0);

    // Passthrough with out_ready high: each word visible right after its accepting edge
    drive(1'b1, 16'h0011, 16'h0100, 1'b1, 1'b0);
    check("pt_data0", 32'(out_data), 32'h0011);
    drive(1'b1, 16'h0022, 16'h0101, 1'b1, 1'b0);
    check("pt_data1", 32'(out_data), 32'h0022);
    check("pt_occ1",  32'(occupancy), 32'd1);
    drive(1'b1, 16'h0033, 16'h0102, 1'b1, 1'b0);
    check("pt_data2", 32'(out_data), 32'h0033);
    check("pt_pc2",   32'(out_pc),   32'h0102);
    idle(1'b1);
    check("pt_drained", 32'(occupancy), 32'd0);

    // Back-pressure: two words held, third refused while FULL
    drive(1'b1, 16'hAAAA, 16'h0200, 1'b0, 1'b0);
    check("bp_occ1", 32'(occupancy), 32'd1);
    drive(1'b1, 16'hBBBB, 16'h0201, 1'b0, 1'b0);
    check("bp_occ2",     32'(occupancy), 32'd2);
    check("bp_in_ready", 32'(in_ready),  32'd0);
    check("bp_head",     32'(out_data),  32'hAAAA);
    drive(1'b1, 16'hCCCC, 16'h0202, 1'b0, 1'b0);
    check("bp_head_stable", {out_data, out_pc}, {16'hAAAA, 16'h0200});
    check("bp_occ_full",    32'(occupancy), 32'd2);
    idle(1'b1);
    check("bp_next_head", {out_data, out_pc}, {16'hBBBB, 16'h0201});
    check("bp_occ_after", 32'(occupancy), 32'd1);
    check("bp_ready_back", 32'(in_ready), 32'd1);
    idle(1'b1);
    check("bp_drained", 32'(occupancy), 32'd0);

    // Simultaneous accept and consume while ONE
    drive(1'b1, 16'h0005, 16'h0300, 1'b0, 1'b0);
    drive(1'b1, 16'h0006, 16'h0301, 1'b1, 1'b0);
    check("sim_occ",  32'(occupancy), 32'd1);
    check("sim_head", {out_data, out_pc}, {16'h0006, 16'h0301});
    idle(1'b1);

    // Flush from FULL with a word presented: everything discarded
    drive(1'b1, 16'h1111, 16'h0400, 1'b0, 1'b0);
    drive(1'b1, 16'h2222, 16'h0401, 1'b0, 1'b0);
    check("fl_full", 32'(occupancy), 32'd2);
    drive(1'b1, 16'h3333, 16'h0402, 1'b0, 1'b1);
    check("fl_occ",       32'(occupancy), 32'd0);
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_out_data",  32'(out_data),  32'h0000);
    check("fl_out_pc",    32'(out_pc),    32'h0000);
    check("fl_in_ready",  32'(in_ready),  32'd1);

    // Flush from ONE with an accepted incoming word: that word is squashed too
    drive(1'b1, 16'h4444, 16'h0410, 1'b0, 1'b0);
    drive(1'b1, 16'h5555, 16'h0411, 1'b0, 1'b1);
    check("fl1_occ", 32'(occupancy), 32'd0);
    idle(1'b1);
    idle(1'b1);
    check("fl1_stays_empty", 32'(out_valid), 32'd0);

    // Async reset while FULL, asserted between edges
    drive(1'b1, 16'h7777, 16'h0500, 1'b0, 1'b0);
    drive(1'b1, 16'h8888, 16'h0501, 1'b0, 1'b0);
    check("ar_full", 32'(occupancy), 32'd2);
    in_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_out_data",  32'(out_data),  32'h0000);
    check("ar_occ",       32'(occupancy), 32'd0);
    check("ar_in_ready",  32'(in_ready),  32'd1);
    exp_q.delete();
    @(posedge CLK);
    #1 reset = 1'b1;

    // Clean passthrough after reset
    drive(1'b1, 16'h9999, 16'h0600, 1'b1, 1'b0);
    check("post_head", {out_data, out_pc}, {16'h9999, 16'h0600});
    idle(1'b1);
    idle(1'b1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
